// File: rtl/btn_debounce_pkg.sv
// ----------------------------------------------------------------------------
// btn_debounce_pkg
// Shared definitions for the push-button debouncer:
//   db_state_e                - per-channel qualification FSM state
//   DB_STABLE_CYCLES_DEFAULT  - default stability window (10 ms at 50 MHz)
//   DB_CNT_W_DEFAULT          - default stability counter width
// ----------------------------------------------------------------------------
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

    localparam int unsigned DB_STABLE_CYCLES_DEFAULT = 500_000;
    localparam int unsigned DB_CNT_W_DEFAULT         = 20;

endpackage

// File: rtl/btn_debounce_ch.sv
// ----------------------------------------------------------------------------
// btn_debounce_ch
// Single debounce channel: 2-FF synchroniser, stability counter and a
// four-state qualification FSM with registered level and edge strobes.
// Ports:
//   clk_i    - system clock
//   rst_i    - asynchronous active-high reset
//   btn_i    - raw asynchronous button pin
//   level_o  - debounced level
//   rise_o   - one-cycle strobe on an accepted 0->1 transition
//   fall_o   - one-cycle strobe on an accepted 1->0 transition
// ----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = DB_CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Plain flop-to-flop chain; nothing may sit between the two stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    // An opposite sample in a WAIT state drops straight back to the idle
    // state, so the counter restarts from zero on the next attempt and can
    // never pass TERM_CNT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LO: begin
                    if (sync_q) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_q) begin
                        state_q <= IDLE_LO;
                    end else if (cnt_q == TERM_CNT) begin
                        state_q <= IDLE_HI;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE_HI: begin
                    if (!sync_q) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_q) begin
                        state_q <= IDLE_HI;
                    end else if (cnt_q == TERM_CNT) begin
                        state_q <= IDLE_LO;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// N independent push-button conditioning channels (synchronise, debounce,
// edge-detect) between the raw pins and the display/RAM datapath.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   btn_in     - raw button pins, bit i is channel i
//   btn_level  - debounced level per channel
//   btn_rise   - one-cycle strobe per channel on an accepted press
//   btn_fall   - one-cycle strobe per channel on an accepted release
// ----------------------------------------------------------------------------
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N             = 2,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = DB_CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_rise,
    output logic [N-1:0] btn_fall
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk_i   (clk),
            .rst_i   (rst),
            .btn_i   (btn_in[g]),
            .level_o (btn_level[g]),
            .rise_o  (btn_rise[g]),
            .fall_o  (btn_fall[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    localparam int unsigned N  = 2;
    localparam int unsigned SC = 4;
    localparam int unsigned CW = 3;
    // Strobe is visible after edge SC+2 counted from edge 0, i.e. SC+3
    // posedges after the negedge at which the input was driven.
    localparam int LAT = SC + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;

    btn_debounce #(
        .N             (N),
        .STABLE_CYCLES (SC),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] level;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_strobe(input logic [1:0] r, input logic [1:0] f, input logic [1:0] l);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.rise  = r;
        e.fall  = f;
        e.level = l;
        q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: every strobe the DUT presents consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_strobe: got none expected strobe at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if ((btn_rise | btn_fall) != '0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got rise=%b fall=%b expected none (cycle %0d)",
                         btn_rise, btn_fall, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_rise", int'(btn_rise), int'(e.rise));
                chk("strobe_fall", int'(btn_fall), int'(e.fall));
                chk("strobe_level", int'(btn_level), int'(e.level));
            end
        end
    end

    initial begin
        logic [5:0] bounce;
        bounce = 6'b011011; // applied LSB first: 1,1,0,1,1,0

        repeat (3) @(negedge clk);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_rise", int'(btn_rise), 0);
        chk("reset_fall", int'(btn_fall), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press on channel 0
        btn_in = 2'b01;
        expect_strobe(2'b01, 2'b00, 2'b01);
        wait_empty("press");
        repeat (2) @(negedge clk);
        chk("press_level", int'(btn_level), 1);

        // Release on channel 0
        btn_in = 2'b00;
        expect_strobe(2'b00, 2'b01, 2'b00);
        wait_empty("release");
        repeat (2) @(negedge clk);
        chk("release_level", int'(btn_level), 0);

        // Bounce then settle high
        for (int i = 0; i < 6; i++) begin
            btn_in = {1'b0, bounce[i]};
            @(negedge clk);
        end
        btn_in = 2'b01;
        expect_strobe(2'b01, 2'b00, 2'b01);
        wait_empty("bounce");
        btn_in = 2'b00;
        expect_strobe(2'b00, 2'b01, 2'b00);
        wait_empty("bounce_release");

        // Short glitch on channel 1
        btn_in = 2'b10;
        repeat (3) @(negedge clk);
        btn_in = 2'b00;
        repeat (15) @(negedge clk);
        chk("glitch_level", int'(btn_level), 0);

        // Channel 1 pressed, channel 0 mid-qualification, then reset
        btn_in = 2'b10;
        expect_strobe(2'b10, 2'b00, 2'b10);
        wait_empty("ch1_press");
        btn_in = 2'b11;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", int'(btn_level), 0);
        chk("async_rst_rise", int'(btn_rise), 0);
        chk("async_rst_fall", int'(btn_fall), 0);
        @(negedge clk);
        rst = 1'b0;
        expect_strobe(2'b11, 2'b00, 2'b11);
        wait_empty("post_reset");

        // Simultaneous release then simultaneous press
        btn_in = 2'b00;
        expect_strobe(2'b00, 2'b11, 2'b00);
        wait_empty("both_release");
        btn_in = 2'b11;
        expect_strobe(2'b11, 2'b00, 2'b11);
        wait_empty("both_press");
        repeat (10) @(negedge clk);
        chk("final_level", int'(btn_level), 3);
        chk("final_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the board push-buttons, inserted between the raw pins and the display/RAM datapath.
- Per channel:
  - synchronises the asynchronous pin;
  - rejects contact bounce with a stability counter;
  - emits a clean level plus one-cycle rise and fall strobes.
- Downstream usage: btn_level feeds the 4-bit counter reset; btn_rise gates the RAM write-enable mux, so one press produces exactly one write.

Parameters:
- N, 2, number of independent button channels.
- STABLE_CYCLES, 500_000, consecutive cycles the synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  N  raw, asynchronous, bouncing button pins; bit i is channel i.
- btn_level  output  N  debounced level per channel.
- btn_rise  output  N  one-cycle strobe when a debounced level goes 0->1.
- btn_fall  output  N  one-cycle strobe when a debounced level goes 1->0.

Behaviour:
- One clock; reset is asynchronous and active-high: clk and rst.
- Reset values (all registers): sync flops 0, counter 0, FSM IDLE_LO, btn_level 0, btn_rise 0, btn_fall 0.
- Synchroniser: 2-FF chain per channel; sync = second flop. No logic between the flops.
- Per-channel FSM, 4 states; counter cnt is CNT_W bits.
  - IDLE_LO: sync=1 -> WAIT_HI, cnt<=0; else stay.
  - WAIT_HI: sync=0 -> IDLE_LO (bounce abort, no strobe). cnt==STABLE_CYCLES-1 -> IDLE_HI, btn_level<=1, btn_rise<=1. Otherwise cnt<=cnt+1.
  - IDLE_HI: sync=0 -> WAIT_LO, cnt<=0; else stay.
  - WAIT_LO: mirror of WAIT_HI. sync=1 aborts to IDLE_HI. Terminal count -> IDLE_LO, btn_level<=0, btn_fall<=1.
- Strobes are registered and high for exactly one cycle; cleared on every other edge.
- Latency: let edge 0 be the first clk edge sampling btn_in steady at the new value. btn_level toggles and the strobe asserts after edge STABLE_CYCLES+2. The strobe deasserts after edge STABLE_CYCLES+3.
- Any opposite sample during WAIT restarts the whole qualification from the idle state. A glitch lasting fewer than STABLE_CYCLES synchronised cycles never changes btn_level.
- cnt never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Channels are fully independent. Simultaneous presses on several channels may strobe in the same cycle.
- Reset mid-qualification discards progress; no strobe is emitted.
- Button held through reset release: treated as a fresh press, so btn_rise fires STABLE_CYCLES+2 edges after release.
- btn_rise and btn_fall are never both high on one channel, and can never occur on consecutive cycles of the same channel.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO; 2-bit encoding);
  - default STABLE_CYCLES constant;
  - CNT_W helper constant.
- Sub-module btn_debounce_ch:
  - single channel: synchroniser + counter + FSM, 1-bit ports;
  - instantiated N times in a generate loop by btn_debounce.

Test Plan (STABLE_CYCLES=4, CNT_W=3, N=2):
- Clean press: btn_in[0] 0->1 before edge 0 and held -> btn_level[0]=1 and btn_rise[0]=1 after edge 6; btn_rise[0]=0 after edge 7; channel 1 stays 0.
- Bounce rejection: btn_in[0] pattern 1,1,0,1,1,0 (one value per cycle) then steady 1 -> no strobe during bouncing; single btn_rise 6 edges after the last 0->1.
- Release: from pressed state, btn_in[0] 1->0 held -> btn_fall[0] one cycle and btn_level[0]=0 after edge 6; btn_rise[0] stays 0.
- Short glitch: 3-cycle high pulse on btn_in[1] -> btn_level[1], btn_rise[1], btn_fall[1] all remain 0.
- Reset mid-operation: assert rst asynchronously mid-WAIT_HI -> all outputs 0 immediately. Release with button still held -> btn_rise 6 edges after release.
- Simultaneous channels: both inputs rise on the same cycle -> btn_rise=2'b11 on the same cycle; both btn_level bits high.
